// File: rtl/axi4_burst_master_pkg.sv
// rtl/axi4_burst_master_pkg.sv - shared types and constants for the AXI4 burst master
//
// Purpose: FSM state type, fixed AXI burst attributes, response codes,
// watchdog counter width and the response-merge helper.
package axi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } state_e;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int TO_W = 8;

  // Worst-of merge: response codes are ordered by severity numerically.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_burst_master_if.sv
// rtl/axi4_burst_master_if.sv - AXI4 AW/W/B/AR/R channel bundle
//
// Purpose: groups the five AXI4 channels between initiator and slave.
// Ports (master view): AW payload/valid out, awready in; W payload/valid out,
// wready in; B bready out, bresp/bid/bvalid in; AR payload/valid out,
// arready in; R rready out, rdata/rresp/rlast/rvalid in.
interface axi4_burst_master_if;

  logic [5:0]  awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awid;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bid;
  logic        bvalid;
  logic        bready;

  logic [5:0]  araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awid, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bid, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awid, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bid, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi4_burst_master_watchdog.sv
// rtl/axi4_burst_master_watchdog.sv - handshake timeout counter
//
// Purpose: counts cycles without a channel handshake.
// Ports: clk/rst_n; clear (restart from zero, wins over enable); enable
// (count this cycle); limit (expiry value); expired (count reached limit
// while enabled).
module axi_watchdog
  import axi_master_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            enable,
  input  logic [TO_W-1:0] limit,
  output logic            expired
);

  logic [TO_W-1:0] count_q;

  // Saturates at the limit so a stalled AW/W/AR wait cannot wrap around.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = enable && (count_q == limit);

endmodule

// File: rtl/axi4_burst_master.sv
// rtl/axi4_burst_master.sv - command-driven AXI4 INCR burst initiator
//
// Purpose: turns one write/read command into a complete AXI4 INCR burst.
// Ports: m00_axi_aclk/m00_axi_aresetn clock and async active-low reset;
// cmd_* command handshake (write flag, byte address, len = beats-1);
// wr_* write-beat stream in; rd_* read-beat stream out; done_valid one-cycle
// completion pulse with done_resp (worst response) and done_err; busy;
// m00_axi master side of the AXI4 channels.
module axi4_burst_master
  import axi_master_pkg::*;
#(
  parameter logic ID_VAL  = 1'b1,
  parameter int   TIMEOUT = 255
) (
  input  logic                        m00_axi_aclk,
  input  logic                        m00_axi_aresetn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [5:0]                  cmd_addr,
  input  logic [7:0]                  cmd_len,
  input  logic [31:0]                 wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  output logic [31:0]                 rd_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic                        rd_last,
  output logic                        done_valid,
  output logic [1:0]                  done_resp,
  output logic                        done_err,
  output logic                        busy,
  axi4_burst_master_if.master         m00_axi
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  state_e     state_q, state_d;
  logic [5:0] addr_q;
  logic [7:0] len_q;
  logic [7:0] cnt_q;
  logic [1:0] resp_q;
  logic       err_q;

  logic last_beat;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
  logic wd_clear, wd_enable, to_expired;

  assign last_beat = (cnt_q == len_q);

  // Channel outputs are derived from the state register so that an
  // asynchronous reset drops every valid/ready in the same instant.
  assign m00_axi.awaddr  = addr_q;
  assign m00_axi.awlen   = len_q;
  assign m00_axi.awsize  = AXI_SIZE_4B;
  assign m00_axi.awburst = AXI_BURST_INCR;
  assign m00_axi.awid    = ID_VAL;
  assign m00_axi.awvalid = (state_q == ST_AW);

  assign m00_axi.wdata   = (state_q == ST_W) ? wr_data : '0;
  assign m00_axi.wstrb   = 4'hF;
  assign m00_axi.wlast   = (state_q == ST_W) && last_beat;
  assign m00_axi.wvalid  = (state_q == ST_W) && wr_valid;
  assign wr_ready        = (state_q == ST_W) && m00_axi.wready;

  // On timeout the ready is withdrawn in the same cycle the FSM leaves,
  // so a late response cannot complete a handshake we have abandoned.
  assign m00_axi.bready  = (state_q == ST_B) && !to_expired;

  assign m00_axi.araddr  = addr_q;
  assign m00_axi.arlen   = len_q;
  assign m00_axi.arsize  = AXI_SIZE_4B;
  assign m00_axi.arburst = AXI_BURST_INCR;
  assign m00_axi.arvalid = (state_q == ST_AR);

  assign m00_axi.rready  = (state_q == ST_R) && rd_ready && !to_expired;
  assign rd_valid        = (state_q == ST_R) && m00_axi.rvalid;
  assign rd_data         = (state_q == ST_R) ? m00_axi.rdata : '0;
  assign rd_last         = (state_q == ST_R) && m00_axi.rlast;

  assign aw_hs  = m00_axi.awvalid && m00_axi.awready;
  assign w_hs   = m00_axi.wvalid  && m00_axi.wready;
  assign b_hs   = m00_axi.bvalid  && m00_axi.bready;
  assign ar_hs  = m00_axi.arvalid && m00_axi.arready;
  assign r_hs   = m00_axi.rvalid  && m00_axi.rready;
  assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;

  assign cmd_ready  = (state_q == ST_IDLE) && m00_axi_aresetn;
  assign busy       = (state_q != ST_IDLE);
  assign done_valid = (state_q == ST_DONE);
  assign done_resp  = resp_q;
  assign done_err   = err_q;

  assign wd_enable = (state_q == ST_AW) || (state_q == ST_W) || (state_q == ST_B) ||
                     (state_q == ST_AR) || (state_q == ST_R);
  assign wd_clear  = (state_d != state_q) || any_hs;

  axi_watchdog u_watchdog (
    .clk     (m00_axi_aclk),
    .rst_n   (m00_axi_aresetn),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .limit   (TO_LIMIT),
    .expired (to_expired)
  );

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // AW/W/AR ignore the timeout for sequencing: a raised valid must stay up
  // until the slave takes it, so only the error flags record the stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) state_d = cmd_write ? ST_AW : ST_AR;
      ST_AW:   if (aw_hs) state_d = ST_W;
      ST_W:    if (w_hs && last_beat) state_d = ST_B;
      ST_B:    if (b_hs || to_expired) state_d = ST_DONE;
      ST_AR:   if (ar_hs) state_d = ST_R;
      ST_R:    if ((r_hs && last_beat) || to_expired) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      resp_q <= RESP_OKAY;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            cnt_q  <= '0;
            resp_q <= RESP_OKAY;
            err_q  <= 1'b0;
          end
        end
        ST_W: begin
          if (w_hs && !last_beat) cnt_q <= cnt_q + 8'd1;
        end
        ST_B: begin
          if (b_hs) begin
            resp_q <= resp_max(resp_q, m00_axi.bresp);
            if (m00_axi.bid != ID_VAL) err_q <= 1'b1;
          end
        end
        ST_R: begin
          if (r_hs) begin
            resp_q <= resp_max(resp_q, m00_axi.rresp);
            if (m00_axi.rlast != last_beat) err_q <= 1'b1;
            if (!last_beat) cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
      if (to_expired) begin
        err_q  <= 1'b1;
        resp_q <= RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// tb/tb_axi4_burst_master.sv - self-checking bench for axi4_burst_master
module tb_axi4_burst_master;
  import axi_master_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [5:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_ready, rd_last;
  logic        done_valid, done_err, busy;
  logic [1:0]  done_resp;

  axi4_burst_master_if m00_axi();

  axi4_burst_master #(.ID_VAL(1'b1), .TIMEOUT(255)) dut (
    .m00_axi_aclk    (clk),
    .m00_axi_aresetn (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_len         (cmd_len),
    .wr_data         (wr_data),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .rd_last         (rd_last),
    .done_valid      (done_valid),
    .done_resp       (done_resp),
    .done_err        (done_err),
    .busy            (busy),
    .m00_axi         (m00_axi)
  );

  typedef struct {
    bit         wr;
    logic [5:0] addr;
    logic [7:0] len;
    logic [7:0] base;       // beat i data = {4{base + 34*i}}
    logic [1:0] bresp;
    logic       bid;
    bit         no_b;       // slave never answers on B
    int         rlast_at;   // beat index carrying rlast (> len: never)
    logic [1:0] rresp_last; // rresp of the final read beat, others OKAY
    int         w_stall;    // cycles wready low on beat 1
    int         rd_hold;    // cycles rd_ready low on the first read beat
    int         rst_at;     // assert reset once this many W beats are done
    int         exp_lat;    // accept -> done_valid cycles, -1 unchecked
    logic [1:0] exp_resp;
    logic       exp_err;
  } vec_t;

  vec_t tbl [12];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 0; rd_ready = 0;
    m00_axi.awready = 0; m00_axi.wready = 0; m00_axi.arready = 0;
    m00_axi.bvalid = 0; m00_axi.bresp = '0; m00_axi.bid = 0;
    m00_axi.rvalid = 0; m00_axi.rdata = '0; m00_axi.rresp = '0; m00_axi.rlast = 0;
  endtask

  function automatic logic [87:0] quiet_outs();
    return {m00_axi.awvalid, m00_axi.wvalid, m00_axi.bready, m00_axi.arvalid, m00_axi.rready,
            done_valid, busy, wr_ready, rd_valid, cmd_ready,
            m00_axi.awaddr, m00_axi.awlen, m00_axi.wdata, rd_data};
  endfunction

  function automatic bit coin(input bit rnd);
    return rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // Runs one command against a slave model; the bench keeps the beat queues
  // and derives the expected completion from the responses it handed out.
  task automatic run_txn(input vec_t v, input bit rnd);
    logic [31:0] wq[$];
    logic [31:0] rq[$];
    logic [1:0]  rr[$];
    logic [7:0]  b;
    logic [1:0]  m_resp;
    logic        m_err;
    int  len = int'(v.len);
    int  wn = 0, rn = 0, cyc = 0, acc = -1, stall = 0, hold = 0;
    bit  aw_done = 0, ar_done = 0, w_done = 0, b_done = 0, got = 0, prev_bready = 0;
    bit  cmd_h, aw_h, w_h, b_h, ar_h, r_h;

    for (int i = 0; i <= len; i++) begin
      b = v.base + 8'(34 * i);
      wq.push_back(rnd ? $urandom : {4{b}});
      rq.push_back(rnd ? $urandom : {4{b}});
      rr.push_back(rnd ? 2'($urandom_range(0, 3)) : ((i == len) ? v.rresp_last : RESP_OKAY));
    end
    m_resp = RESP_OKAY;
    if (v.wr) m_resp = v.bresp;
    else foreach (rr[i]) if (rr[i] > m_resp) m_resp = rr[i];
    m_err = v.wr ? (v.bid != 1'b1) : (v.rlast_at != len);
    if (!rnd) begin m_resp = v.exp_resp; m_err = v.exp_err; end

    idle_inputs();
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;

    while (!got && cyc < 2000) begin
      m00_axi.awready = coin(rnd);
      m00_axi.arready = coin(rnd);
      if (v.wr && wn <= len) begin
        if (!wr_valid) wr_valid = coin(rnd);
        wr_data = wq[wn];
      end else begin
        wr_valid = 0; wr_data = '0;
      end
      if (rnd) m00_axi.wready = coin(rnd);
      else if (wn == 1 && stall < v.w_stall) begin m00_axi.wready = 0; stall++; end
      else m00_axi.wready = 1;
      if (!m00_axi.bvalid) m00_axi.bvalid = v.wr && w_done && !b_done && !v.no_b && coin(rnd);
      m00_axi.bresp = v.bresp; m00_axi.bid = v.bid;
      if (!v.wr && ar_done && rn <= len) begin
        if (!m00_axi.rvalid) m00_axi.rvalid = coin(rnd);
        m00_axi.rdata = rq[rn]; m00_axi.rresp = rr[rn]; m00_axi.rlast = (rn == v.rlast_at);
      end else begin
        m00_axi.rvalid = 0; m00_axi.rdata = '0; m00_axi.rresp = '0; m00_axi.rlast = 0;
      end
      if (m00_axi.rvalid && hold < v.rd_hold) begin rd_ready = 0; hold++; end
      else rd_ready = coin(rnd);
      #1;

      cmd_h = cmd_valid && cmd_ready;
      aw_h  = m00_axi.awvalid && m00_axi.awready;
      w_h   = m00_axi.wvalid && m00_axi.wready;
      b_h   = m00_axi.bvalid && m00_axi.bready;
      ar_h  = m00_axi.arvalid && m00_axi.arready;
      r_h   = m00_axi.rvalid && m00_axi.rready;
      if (cmd_h) acc = cyc;
      if (m00_axi.awvalid)
        chk("aw_payload", {v.wr, m00_axi.awaddr, m00_axi.awlen, m00_axi.awsize, m00_axi.awburst, m00_axi.awid},
            {1'b1, v.addr, v.len, 3'b010, 2'b01, 1'b1});
      if (m00_axi.wvalid) begin
        if (wn <= len)
          chk("w_beat", {aw_done, m00_axi.wdata, m00_axi.wstrb, m00_axi.wlast, wr_ready},
              {1'b1, wq[wn], 4'hF, wn == len, m00_axi.wready});
        else
          chk("w_extra_beat", m00_axi.wvalid, 1'b0);
      end
      if (m00_axi.arvalid)
        chk("ar_payload", {!v.wr, m00_axi.araddr, m00_axi.arlen, m00_axi.arsize, m00_axi.arburst},
            {1'b1, v.addr, v.len, 3'b010, 2'b01});
      if (m00_axi.rvalid)
        chk("r_beat", {rd_valid, rd_data, rd_last, m00_axi.rready},
            {1'b1, rq[rn], rn == v.rlast_at, rd_ready});
      if (done_valid) begin
        got = 1;
        chk("done_out", {done_resp, done_err, cmd_ready, busy}, {m_resp, m_err, 1'b0, 1'b1});
        chk("beat_count", v.wr ? wn : rn, len + 1);
        if (v.exp_lat >= 0) chk("done_latency", cyc - acc, v.exp_lat);
        if (v.no_b) chk("bready_at_timeout", prev_bready, 1'b0);
      end else begin
        prev_bready = m00_axi.bready;
      end

      @(posedge clk); #1;
      if (cmd_h) cmd_valid = 0;
      if (aw_h) aw_done = 1;
      if (ar_h) ar_done = 1;
      if (w_h) begin wn++; wr_valid = 0; if (wn > len) w_done = 1; end
      if (b_h) begin m00_axi.bvalid = 0; b_done = 1; end
      if (r_h) begin rn++; m00_axi.rvalid = 0; end
      cyc++;

      if (v.rst_at >= 0 && wn == v.rst_at && !got) begin
        #2 rst_n = 0;
        #1 chk("reset_async", quiet_outs(), '0);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < 4; i++) begin
          @(posedge clk); #1;
          chk("after_reset_idle", {done_valid, cmd_ready, busy}, 3'b010);
        end
        return;
      end
    end

    if (!got) chk("done_wait_expired", done_valid, 1'b1);
    idle_inputs();
    if (got) chk("idle_after_done", {done_valid, cmd_ready, busy}, 3'b010);
  endtask

  initial begin
    vec_t v;
    //          wr    addr   len   base   bresp bid   no_b rl rresp w_st rd_h rst lat resp  err
    tbl[0]  = '{1'b1, 6'h04, 8'd0, 8'hFF, 2'd0, 1'b1, 1'b0, 0, 2'd0, 0, 0, -1,   4, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 6'h08, 8'd2, 8'hAB, 2'd0, 1'b1, 1'b0, 2, 2'd0, 2, 0, -1,  -1, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 6'h04, 8'd0, 8'hAA, 2'd0, 1'b1, 1'b0, 0, 2'd0, 0, 0, -1,   3, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 6'h10, 8'd1, 8'h11, 2'd0, 1'b1, 1'b0, 0, 2'd0, 0, 0, -1,  -1, 2'd0, 1'b1};
    tbl[4]  = '{1'b0, 6'h10, 8'd1, 8'h11, 2'd0, 1'b1, 1'b0, 0, 2'd0, 0, 3, -1,  -1, 2'd0, 1'b1};
    tbl[5]  = '{1'b1, 6'h0C, 8'd0, 8'h5A, 2'd0, 1'b1, 1'b1, 0, 2'd0, 0, 0, -1, 259, 2'd2, 1'b1};
    tbl[6]  = '{1'b1, 6'h14, 8'd1, 8'h01, 2'd0, 1'b0, 1'b0, 1, 2'd0, 0, 0, -1,  -1, 2'd0, 1'b1};
    tbl[7]  = '{1'b1, 6'h18, 8'd0, 8'h02, 2'd3, 1'b1, 1'b0, 0, 2'd0, 0, 0, -1,  -1, 2'd3, 1'b0};
    tbl[8]  = '{1'b0, 6'h1C, 8'd2, 8'h03, 2'd0, 1'b1, 1'b0, 2, 2'd1, 0, 0, -1,  -1, 2'd1, 1'b0};
    tbl[9]  = '{1'b0, 6'h20, 8'd1, 8'h04, 2'd0, 1'b1, 1'b0, 2, 2'd0, 0, 0, -1,  -1, 2'd0, 1'b1};
    tbl[10] = '{1'b1, 6'h24, 8'd2, 8'h05, 2'd0, 1'b1, 1'b0, 2, 2'd0, 0, 0,  1,  -1, 2'd0, 1'b0};
    tbl[11] = '{1'b1, 6'h28, 8'd0, 8'h06, 2'd0, 1'b1, 1'b0, 0, 2'd0, 0, 0, -1,   4, 2'd0, 1'b0};

    idle_inputs();
    rst_n = 0;
    cmd_valid = 1; cmd_write = 1;
    wr_data = 32'hDEADBEEF; wr_valid = 1; rd_ready = 1;
    m00_axi.rvalid = 1; m00_axi.rdata = 32'h12345678;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", quiet_outs(), '0);
    idle_inputs();
    rst_n = 1;
    @(posedge clk); #1;
    chk("ready_after_release", {cmd_ready, busy, done_valid}, 3'b100);

    foreach (tbl[i]) run_txn(tbl[i], 1'b0);

    for (int t = 0; t < 30; t++) begin
      v.wr         = 1'($urandom_range(0, 1));
      v.addr       = {4'($urandom_range(0, 15)), 2'b00};
      v.len        = 8'($urandom_range(0, 7));
      v.base       = '0;
      v.bresp      = 2'($urandom_range(0, 3));
      v.bid        = ($urandom_range(0, 3) != 0);
      v.no_b       = 1'b0;
      v.rlast_at   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(v.len) + 1)) : int'(v.len);
      v.rresp_last = RESP_OKAY;
      v.w_stall    = 0;
      v.rd_hold    = 0;
      v.rst_at     = -1;
      v.exp_lat    = -1;
      v.exp_resp   = RESP_OKAY;
      v.exp_err    = 1'b0;
      run_txn(v, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish, %0d mismatched so far", n_bad);
    $fatal(1);
  end

endmodule
